// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the BTB-based branch predictor.
`default_nettype none

package branch_predictor_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int BTB_IDX_W   = 4;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_e;

  function automatic logic ctr_predicts_taken(input ctr_e ctr);
    return (ctr == WEAK_T) || (ctr == STRONG_T);
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic for a 2-bit saturating direction counter.
`default_nettype none

module branch_predictor_sat_counter2
  import branch_predictor_pkg::*;
(
  input  ctr_e ctr,
  input  logic taken,
  output ctr_e ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      unique case (ctr)
        STRONG_NT: ctr_next = WEAK_NT;
        WEAK_NT:   ctr_next = WEAK_T;
        WEAK_T:    ctr_next = STRONG_T;
        STRONG_T:  ctr_next = STRONG_T;
      endcase
    end else begin
      unique case (ctr)
        STRONG_NT: ctr_next = STRONG_NT;
        WEAK_NT:   ctr_next = STRONG_NT;
        WEAK_T:    ctr_next = WEAK_NT;
        STRONG_T:  ctr_next = WEAK_T;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational IF-stage lookup,
// registered training from EX, plus saturating branch/miss perf counters.
`default_nettype none

module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = BTB_IDX_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  inst_addr_t       if_pc_i,
  output logic             prediction_o,
  output inst_addr_t       prediction_pc_o,
  input  logic             upd_valid_i,
  input  inst_addr_t       upd_pc_i,
  input  logic             upd_taken_i,
  input  inst_addr_t       upd_target_i,
  input  logic             upd_mispredict_i,
  output logic [CNT_W-1:0] perf_branch_cnt_o,
  output logic [CNT_W-1:0] perf_miss_cnt_o
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = INST_ADDR_W - 2 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  ctr_e               ctr_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  inst_addr_t         target_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  ctr_e             upd_ctr_next;

  // Byte-offset bits of word-aligned PCs carry no information.
  wire unused_pc_lsbs = ^{if_pc_i[1:0], upd_pc_i[1:0]};

  assign lk_idx = if_pc_i[IDX_W+1:2];
  assign lk_tag = if_pc_i[INST_ADDR_W-1:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign prediction_o    = lk_hit && ctr_predicts_taken(ctr_q[lk_idx]);
  assign prediction_pc_o = prediction_o ? target_q[lk_idx] : (if_pc_i + 32'd4);

  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[INST_ADDR_W-1:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  branch_predictor_sat_counter2 u_sat_counter2 (
    .ctr      (ctr_q[upd_idx]),
    .taken    (upd_taken_i),
    .ctr_next (upd_ctr_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q           <= '0;
      perf_branch_cnt_o <= '0;
      perf_miss_cnt_o   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= STRONG_NT;
      end
    end else if (upd_valid_i) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= upd_ctr_next;
      end else if (upd_taken_i) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= WEAK_T;
      end
      if (perf_branch_cnt_o != '1) begin
        perf_branch_cnt_o <= perf_branch_cnt_o + CNT_W'(1);
      end
      if (upd_mispredict_i && (perf_miss_cnt_o != '1)) begin
        perf_miss_cnt_o <= perf_miss_cnt_o + CNT_W'(1);
      end
    end
  end

  // Tag/target are qualified by valid_q, so they need no reset. A taken
  // update writes them on both hit (tag unchanged) and allocation.
  always_ff @(posedge clk) begin
    if (!rst && upd_valid_i && upd_taken_i) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= upd_target_i;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
`default_nettype none

module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        prediction;
  logic [31:0] prediction_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] perf_branch_cnt;
  logic [31:0] perf_miss_cnt;

  int vectors = 0;
  int misses  = 0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_W(4), .CNT_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .if_pc_i           (if_pc),
    .prediction_o      (prediction),
    .prediction_pc_o   (prediction_pc),
    .upd_valid_i       (upd_valid),
    .upd_pc_i          (upd_pc),
    .upd_taken_i       (upd_taken),
    .upd_target_i      (upd_target),
    .upd_mispredict_i  (upd_mispredict),
    .perf_branch_cnt_o (perf_branch_cnt),
    .perf_miss_cnt_o   (perf_miss_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_pred, input logic [31:0] exp_pc);
    if_pc = pc;
    #1;
    chk({tag, "_pred"}, {31'd0, prediction}, {31'd0, exp_pred});
    chk({tag, "_pc"}, prediction_pc, exp_pc);
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken,
                     input logic [31:0] target, input logic mis);
    @(negedge clk);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_taken      = taken;
    upd_target     = target;
    upd_mispredict = mis;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_pc = 32'h0; upd_valid = 1'b0; upd_pc = 32'h0;
    upd_taken = 1'b0; upd_target = 32'h0; upd_mispredict = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    look("rst_lookup", 32'h100, 1'b0, 32'h104);
    chk("rst_branch_cnt", perf_branch_cnt, 32'd0);
    chk("rst_miss_cnt", perf_miss_cnt, 32'd0);

    // Allocation and strengthening: 10 -> 11 -> 11 (saturated)
    upd(32'h100, 1'b1, 32'h200, 1'b0);
    look("alloc", 32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b1, 32'h200, 1'b0);
    upd(32'h100, 1'b1, 32'h200, 1'b0);
    // Two not-taken from 11 -> 10 (taken) -> 01 (not taken)
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    look("ctr_10", 32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    look("ctr_01", 32'h100, 1'b0, 32'h104);
    // Three more not-taken saturate at 00; two taken then reach 01, 10
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    upd(32'h100, 1'b1, 32'h200, 1'b0);
    look("sat00_then_01", 32'h100, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h200, 1'b0);
    look("sat00_then_10", 32'h100, 1'b1, 32'h200);
    // Taken hit refreshes the target
    upd(32'h100, 1'b1, 32'h240, 1'b0);
    look("target_refresh", 32'h100, 1'b1, 32'h240);

    // Alias on idx 0: 0x140 evicts 0x100
    upd(32'h140, 1'b1, 32'h300, 1'b0);
    look("alias_evicted", 32'h100, 1'b0, 32'h104);
    look("alias_new", 32'h140, 1'b1, 32'h300);
    upd(32'h180, 1'b0, 32'h500, 1'b1);
    look("miss_nt_keep", 32'h140, 1'b1, 32'h300);
    look("miss_nt_noalloc", 32'h180, 1'b0, 32'h184);

    // PC+4 wraps
    look("pc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    // Clean slate, then same-cycle lookup/update (no bypass)
    do_reset();
    look("reset_clears", 32'h140, 1'b0, 32'h144);
    @(negedge clk);
    if_pc = 32'h100;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
    upd_target = 32'h200; upd_mispredict = 1'b0;
    #1;
    chk("same_cycle_pc", prediction_pc, 32'h104);
    @(posedge clk);
    #1 upd_valid = 1'b0;
    look("next_cycle", 32'h100, 1'b1, 32'h200);

    // Inactive update inputs are ignored
    @(negedge clk);
    upd_pc = 32'h10C; upd_taken = 1'b1; upd_target = 32'h700; upd_mispredict = 1'b1;
    @(posedge clk);
    #1;
    look("valid_low_ignored", 32'h10C, 1'b0, 32'h110);
    chk("valid_low_branch_cnt", perf_branch_cnt, 32'd1);
    chk("valid_low_miss_cnt", perf_miss_cnt, 32'd0);

    // Four more updates: 5 total, 2 mispredicted
    upd(32'h100, 1'b0, 32'h0, 1'b1);
    upd(32'h104, 1'b0, 32'h0, 1'b0);
    upd(32'h108, 1'b1, 32'h400, 1'b1);
    upd(32'h100, 1'b1, 32'h200, 1'b0);
    chk("pre_rst_branch_cnt", perf_branch_cnt, 32'd5);
    chk("pre_rst_miss_cnt", perf_miss_cnt, 32'd2);
    look("pre_rst_0x108", 32'h108, 1'b1, 32'h400);

    // Reset beats a same-cycle sixth update
    @(negedge clk);
    rst = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
    upd_target = 32'h200; upd_mispredict = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    upd_valid = 1'b0;
    chk("post_rst_branch_cnt", perf_branch_cnt, 32'd0);
    chk("post_rst_miss_cnt", perf_miss_cnt, 32'd0);
    look("post_rst_0x100", 32'h100, 1'b0, 32'h104);
    look("post_rst_0x108", 32'h108, 1'b0, 32'h10C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

`default_nettype wire
